// File: rtl/operand_sel_pipe_pkg.sv
// Shared definitions for the operand select pipeline: buffer state encoding
// and the default constant substituted on the constant slot.
package operand_sel_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   localparam logic [31:0] DEFAULT_CONST_VAL = 32'd4;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry elastic buffer: a main register that drives the output and a skid
// register that absorbs one transfer while downstream stalls.
module skid_buf2
   import operand_sel_pipe_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   buf_state_e       state;
   buf_state_e       state_next;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             ready_q;
   logic             push;
   logic             pop;
   logic             load_main;
   logic             main_from_skid;
   logic             load_skid;

   // in_ready comes straight from a flop, so out_ready never reaches it.
   assign in_ready  = ready_q;
   assign out_valid = (state != EMPTY) & reset;
   assign out_data  = main_q;

   assign push = in_valid & ready_q & reset;
   assign pop  = out_valid & out_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next     = state;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (push) begin
               state_next = ONE;
               load_main  = 1'b1;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_next = FULL;
               load_skid  = 1'b1;
            end else if (!push && pop) begin
               state_next = EMPTY;
            end else if (push && pop) begin
               load_main = 1'b1;
            end
         end
         FULL: begin
            if (pop) begin
               state_next     = ONE;
               load_main      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
         // NOTE: the data registers are reset as well so out_data reads 0 after reset.
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state   <= state_next;
         ready_q <= (state_next != FULL);
         if (load_main) begin
            main_q <= main_from_skid ? skid_q : in_data;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/operand_sel_pipe.sv
// Selects one of N_IN packed operands (one slot optionally replaced by a
// constant) and passes it through a two-entry valid/ready buffer.
module operand_sel_pipe
   import operand_sel_pipe_pkg::*;
#(
   parameter int                 WIDTH     = 32,
   parameter int                 N_IN      = 4,
   parameter int                 SEL_W     = $clog2(N_IN),
   parameter int                 CONST_IDX = 1,
   parameter logic [WIDTH-1:0]   CONST_VAL = WIDTH'(DEFAULT_CONST_VAL)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sel_err,
   input  logic                  err_clr
);

   logic [WIDTH-1:0] slots [N_IN];
   logic [WIDTH-1:0] sel_val;
   logic             in_range;
   logic             const_hit;
   logic             bad_sel;
   logic             accept;

   for (genvar k = 0; k < N_IN; k++) begin : g_slot
      assign slots[k] = in_data[k*WIDTH +: WIDTH];
   end

   // A CONST_IDX outside the slot range switches the substitution off entirely.
   assign const_hit = (CONST_IDX < N_IN) && (32'(in_sel) == 32'(CONST_IDX));
   assign in_range  = 32'(in_sel) < 32'(N_IN);
   assign bad_sel   = !in_range && !const_hit;
   assign accept    = in_valid & in_ready & reset;

   always_comb begin
      sel_val = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (32'(in_sel) == 32'(k)) begin
            sel_val = slots[k];
         end
      end
      if (const_hit) begin
         sel_val = CONST_VAL;
      end
   end

   skid_buf2 #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .in_data   (sel_val),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // A fresh error wins over a clear arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_err <= 1'b0;
      end else if (accept && bad_sel) begin
         sel_err <= 1'b1;
      end else if (err_clr) begin
         sel_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Self-checking bench: directed steps plus a scoreboard on the default
// configuration, and two extra instances for the select-range corners.
module tb_operand_sel_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // default configuration
   logic [127:0] d0_in;
   logic [1:0]   d0_sel;
   logic         d0_iv, d0_ir, d0_ov, d0_or, d0_err, d0_clr;
   logic [31:0]  d0_out;

   // N_IN = 3: select value 3 is out of range
   logic [95:0]  d1_in;
   logic [1:0]   d1_sel;
   logic         d1_iv, d1_ir, d1_ov, d1_or, d1_err, d1_clr;
   logic [31:0]  d1_out;

   // CONST_IDX = N_IN: constant substitution disabled
   logic [127:0] d2_in;
   logic [1:0]   d2_sel;
   logic         d2_iv, d2_ir, d2_ov, d2_or, d2_err, d2_clr;
   logic [31:0]  d2_out;

   operand_sel_pipe dut0 (
      .clk(clk), .reset(reset), .in_data(d0_in), .in_sel(d0_sel),
      .in_valid(d0_iv), .in_ready(d0_ir), .out_data(d0_out),
      .out_valid(d0_ov), .out_ready(d0_or), .sel_err(d0_err), .err_clr(d0_clr)
   );

   operand_sel_pipe #(.N_IN(3)) dut1 (
      .clk(clk), .reset(reset), .in_data(d1_in), .in_sel(d1_sel),
      .in_valid(d1_iv), .in_ready(d1_ir), .out_data(d1_out),
      .out_valid(d1_ov), .out_ready(d1_or), .sel_err(d1_err), .err_clr(d1_clr)
   );

   operand_sel_pipe #(.CONST_IDX(4)) dut2 (
      .clk(clk), .reset(reset), .in_data(d2_in), .in_sel(d2_sel),
      .in_valid(d2_iv), .in_ready(d2_ir), .out_data(d2_out),
      .out_valid(d2_ov), .out_ready(d2_or), .sel_err(d2_err), .err_clr(d2_clr)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference selection for the default configuration.
   function automatic logic [31:0] model(input logic [127:0] d, input logic [1:0] s);
      if (s == 2'd1) return 32'd4;
      return d[32*s +: 32];
   endfunction

   // Scoreboard on dut0: inputs and outputs are stable at the falling edge.
   logic [31:0] sb_q [$];
   logic        stalled = 1'b0;
   logic [31:0] held    = '0;

   always @(negedge clk) begin
      if (!reset) begin
         sb_q.delete();
         stalled = 1'b0;
      end else begin
         if (stalled && d0_ov) check("stable", d0_out, held);
         if (d0_ov && d0_or) begin
            if (sb_q.size() == 0) check("sb_nonempty", 32'(sb_q.size()), 32'd1);
            else check("sb_data", d0_out, sb_q.pop_front());
         end
         if (d0_iv && d0_ir) sb_q.push_back(model(d0_in, d0_sel));
         stalled = d0_ov && !d0_or;
         held    = d0_out;
      end
   end

   logic [31:0] exp_tab [4];

   initial begin
      reset = 1'b0;
      d0_in = '0; d0_sel = '0; d0_iv = 1'b0; d0_or = 1'b0; d0_clr = 1'b0;
      d1_in = '0; d1_sel = '0; d1_iv = 1'b0; d1_or = 1'b1; d1_clr = 1'b0;
      d2_in = '0; d2_sel = '0; d2_iv = 1'b0; d2_or = 1'b1; d2_clr = 1'b0;

      // reset state
      step();
      step();
      check("rst_out_valid", 32'(d0_ov), 32'd0);
      check("rst_in_ready",  32'(d0_ir), 32'd1);
      check("rst_out_data",  d0_out,     32'd0);
      check("rst_sel_err",   32'(d0_err), 32'd0);
      check("rst_sel_err1",  32'(d1_err), 32'd0);
      reset = 1'b1;

      // one value per cycle, slot 1 replaced by the constant
      exp_tab = '{32'hA, 32'h4, 32'hC, 32'hD};
      d0_or = 1'b1;
      d0_in = {32'hD, 32'hC, 32'hB, 32'hA};
      for (int i = 0; i < 4; i++) begin
         d0_iv  = 1'b1;
         d0_sel = 2'(i);
         step();
         check("stream_valid", 32'(d0_ov), 32'd1);
         check("stream_data",  d0_out,     exp_tab[i]);
      end
      d0_iv = 1'b0;
      step();
      check("stream_idle", 32'(d0_ov), 32'd0);

      // backpressure: fill both entries, then release
      d0_or = 1'b0; d0_sel = 2'd0; d0_iv = 1'b1;
      d0_in = 128'd1;
      step();
      check("bp_ready1", 32'(d0_ir), 32'd1);
      check("bp_data1",  d0_out,     32'd1);
      d0_in = 128'd2;
      step();
      check("bp_ready2", 32'(d0_ir), 32'd0);
      check("bp_data2",  d0_out,     32'd1);
      d0_in = 128'd3;
      step();
      check("bp_ready3", 32'(d0_ir), 32'd0);
      check("bp_hold",   d0_out,     32'd1);
      d0_or = 1'b1;
      step();
      check("bp_rel_data",  d0_out,     32'd2);
      check("bp_rel_ready", 32'(d0_ir), 32'd1);
      step();
      check("bp_third", d0_out, 32'd3);
      d0_iv = 1'b0;
      step();
      check("bp_drained", 32'(d0_ov), 32'd0);

      // reset while full discards both entries
      d0_or = 1'b0; d0_iv = 1'b1;
      d0_in = 128'd5;
      step();
      d0_in = 128'd6;
      step();
      check("full_ready", 32'(d0_ir), 32'd0);
      check("full_valid", 32'(d0_ov), 32'd1);
      reset = 1'b0; d0_iv = 1'b0;
      step();
      check("mid_rst_valid", 32'(d0_ov),  32'd0);
      check("mid_rst_ready", 32'(d0_ir),  32'd1);
      check("mid_rst_err",   32'(d0_err), 32'd0);
      check("mid_rst_data",  d0_out,      32'd0);
      reset = 1'b1; d0_or = 1'b1;
      step();
      check("post_rst_valid", 32'(d0_ov), 32'd0);
      step();
      check("post_rst_valid2", 32'(d0_ov), 32'd0);

      // random traffic against the scoreboard
      for (int c = 0; c < 10000; c++) begin
         d0_iv  = 1'($urandom_range(0, 1));
         d0_or  = 1'($urandom_range(0, 1));
         d0_sel = 2'($urandom_range(0, 3));
         d0_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
      end
      d0_iv = 1'b0; d0_or = 1'b1;
      repeat (4) step();
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      // out-of-range select and sticky error on N_IN = 3
      d1_in = {32'h33, 32'h22, 32'h11};
      d2_in = {32'h44, 32'h33, 32'h1234, 32'h11};
      d1_iv = 1'b1; d1_sel = 2'd3;
      d2_iv = 1'b1; d2_sel = 2'd1;
      step();
      check("bad_data",   d1_out,      32'd0);
      check("bad_valid",  32'(d1_ov),  32'd1);
      check("bad_err",    32'(d1_err), 32'd1);
      check("noconst",    d2_out,      32'h1234);
      check("noconst_err", 32'(d2_err), 32'd0);
      d2_iv = 1'b0;
      d1_sel = 2'd1;
      step();
      check("const3_data", d1_out,      32'd4);
      check("err_sticky",  32'(d1_err), 32'd1);
      d1_sel = 2'd2;
      step();
      check("slot2_data", d1_out, 32'h33);
      d1_iv = 1'b0; d1_clr = 1'b1;
      step();
      check("err_clr", 32'(d1_err), 32'd0);
      d1_iv = 1'b1; d1_sel = 2'd3;
      step();
      check("err_vs_clr", 32'(d1_err), 32'd1);
      d1_iv = 1'b0;
      step();
      check("err_clr2", 32'(d1_err), 32'd0);
      d1_clr = 1'b0;
      step();
      check("idle_bad_sel", 32'(d1_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_sel_pipe.md
OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every input and of the output.
REQ-002 SHALL have parameter N_IN, default 4, number of selectable inputs (legal range 2..16).
REQ-003 SHALL have parameter SEL_W, default $clog2(N_IN), width of the select field.
REQ-004 SHALL have parameter CONST_IDX, default 1, index whose slot is replaced by CONST_VAL; CONST_IDX >= N_IN disables the replacement.
REQ-005 SHALL have parameter CONST_VAL, default 32'd4, constant driven on slot CONST_IDX.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-008 SHALL have port in_data, input, N_IN*WIDTH, packed inputs; slot k is bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port in_sel, input, SEL_W, select field for the current transfer.
REQ-010 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-011 SHALL have port out_data, output, WIDTH, registered selected operand.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-013 SHALL have port sel_err, output, 1, sticky flag for an out-of-range select.
REQ-014 SHALL have port err_clr, input, 1, synchronous clear for sel_err.

Function
REQ-015 SHALL accept an input transfer on a cycle with in_valid=1 and in_ready=1; SHALL emit an output transfer on a cycle with out_valid=1 and out_ready=1.
REQ-016 SHALL compute the selected value combinationally at acceptance: CONST_VAL if in_sel==CONST_IDX; else slot in_sel if in_sel<N_IN; else 0.
REQ-017 SHALL hold accepted values in a main register (drives out_data) and a one-entry skid register, giving a 2-entry buffer.
REQ-018 SHALL implement a state machine with states EMPTY, ONE and FULL.
REQ-019 EMPTY: accept -> ONE; the value loads into the main register.
REQ-020 ONE: accept without pop -> FULL (value loads into skid); pop without accept -> EMPTY; accept and pop together -> stay ONE with the new value in main.
REQ-021 FULL: pop -> ONE (skid moves to main); no accept possible.
REQ-022 SHALL drive in_ready=1 only when the state is not FULL, as a registered signal with no combinational path from out_ready.
REQ-023 SHALL drive out_valid=1 in ONE and FULL; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 SHALL have a latency of 1 cycle from acceptance to out_valid when empty; throughput SHALL be 1 transfer/cycle when out_ready is held high.
REQ-025 SHALL set sel_err on the cycle after an accepted transfer with in_sel>=N_IN and in_sel!=CONST_IDX; the transfer itself SHALL still complete with data 0.
REQ-026 SHALL clear sel_err when err_clr=1; a new error in the same cycle as err_clr SHALL take priority and leave sel_err=1.
REQ-027 SHALL ignore in_sel and in_data on cycles without acceptance.

Reset
REQ-028 On reset=0 at a clock edge: state EMPTY, in_ready=1, out_valid=0, out_data=0, skid=0, sel_err=0.
REQ-029 Reset mid-operation SHALL discard buffered data; no transfer SHALL complete in a reset cycle.

Structure
REQ-030 SHALL put the state encoding typedef (EMPTY, ONE, FULL) and the default CONST_VAL in the shared processor package.
REQ-031 SHALL factor the 2-entry buffer as sub-module skid_buf2 (WIDTH-parametrised); the select/constant logic SHALL stay in the top.

Verification
REQ-032 Defaults, out_ready=1, in_sel=0..3 with slots 0xA,0xB,0xC,0xD -> out_data 0xA, 4, 0xC, 0xD, each one cycle after acceptance.
REQ-033 out_ready=0, three back-to-back valids (values 1,2,3) -> first two accepted, in_ready=0 after the second, out_data stays 1; release out_ready -> outputs 1 then 2, third accepted.
REQ-034 N_IN=3, in_sel=3 accepted -> out_data=0, sel_err=1 the next cycle; err_clr=1 -> sel_err=0; err_clr with a simultaneous bad select -> sel_err stays 1.
REQ-035 FULL state with reset=0 for one cycle -> out_valid=0, in_ready=1, sel_err=0; buffered values never appear.
REQ-036 Random valid/ready streams, 10k cycles, against a scoreboard -> no loss, duplication or reordering; out_data stable while stalled.
REQ-037 CONST_IDX=N_IN, in_sel=1 -> out_data equals slot 1, not CONST_VAL.
